// File: rtl/ie_pkg.sv
// Shared execute-stage types: operand-B source select and the operand register state.
package ie_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int IMM_W_DEF = 12;

  typedef enum logic [1:0] {
    OPB_REG    = 2'd0,
    OPB_IMM_ZX = 2'd1,
    OPB_IMM_SX = 2'd2,
    OPB_HOLD   = 2'd3
  } opb_sel_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } opb_state_e;

endpackage

// File: rtl/ie_operand_mux_if.sv
// Operand-B request/response bundle between the ID/IE boundary (master) and the operand mux (slave).
interface ie_operand_mux_if #(
  parameter int XLEN    = ie_pkg::XLEN_DEF,
  parameter int IMM_W   = ie_pkg::IMM_W_DEF,
  parameter int NUM_FWD = 2
);
  // Handshake: a side transfers on a rising edge when valid && ready; valid may not wait on ready.
  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              sel;
  logic [XLEN-1:0]         rs2_value;
  logic [IMM_W-1:0]        immediate;
  logic [NUM_FWD-1:0]      fwd_hit;
  logic [NUM_FWD*XLEN-1:0] fwd_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN-1:0]         rs2_ALU_in;
  logic                    fwd_used;

  modport master (
    output in_valid, sel, rs2_value, immediate, fwd_hit, fwd_data, out_ready,
    input  in_ready, out_valid, rs2_ALU_in, fwd_used
  );

  modport slave (
    input  in_valid, sel, rs2_value, immediate, fwd_hit, fwd_data, out_ready,
    output in_ready, out_valid, rs2_ALU_in, fwd_used
  );
endinterface

// File: rtl/ie_fwd_pick.sv
// Priority picker over forwarding sources; index 0 is the youngest stage and wins.
module ie_fwd_pick #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic [NUM_FWD-1:0]      fwd_hit_i,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data_i,
  output logic                    hit_any_o,
  output logic [XLEN-1:0]         data_o
);

  // Walk from the oldest source down so the lowest set index is written last.
  always_comb begin
    data_o = '0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_hit_i[i]) data_o = fwd_data_i[i*XLEN +: XLEN];
    end
  end

  assign hit_any_o = |fwd_hit_i;

endmodule

// File: rtl/ie_operand_mux.sv
// Execute-stage operand-B selector with a one-deep valid/ready output register.
// Forwarding is built only when IE_OPMUX_FWD_EN is defined.
module ie_operand_mux
  import ie_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int IMM_W   = IMM_W_DEF,
  parameter int NUM_FWD = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  ie_operand_mux_if.slave  bus,
  output opb_state_e       dbg_state_o
);

  opb_state_e      state_q, state_d;
  logic [XLEN-1:0] op_q, op_d;
  logic [XLEN-1:0] last_q, last_d;
  logic            used_q, used_d;
  logic            xfer_in, xfer_out;
  logic [XLEN-1:0] reg_val;
  logic            reg_fwd;
  opb_sel_e        sel;

  assign sel = opb_sel_e'(bus.sel);

`ifdef IE_OPMUX_FWD_EN
  logic            hit_any;
  logic [XLEN-1:0] fwd_sel;

  ie_fwd_pick #(
    .XLEN    (XLEN),
    .NUM_FWD (NUM_FWD)
  ) u_fwd_pick (
    .fwd_hit_i  (bus.fwd_hit),
    .fwd_data_i (bus.fwd_data),
    .hit_any_o  (hit_any),
    .data_o     (fwd_sel)
  );

  assign reg_val = hit_any ? fwd_sel : bus.rs2_value;
  assign reg_fwd = hit_any;
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus.fwd_hit, bus.fwd_data};
  assign reg_val    = bus.rs2_value;
  assign reg_fwd    = 1'b0;
`endif

  // Ready passes straight through so a full register drained this cycle refills with no bubble.
  assign bus.in_ready = (state_q == ST_EMPTY) || bus.out_ready;
  assign xfer_in      = bus.in_valid && bus.in_ready;
  assign xfer_out     = (state_q == ST_FULL) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    used_d  = used_q;
    last_d  = last_q;

    case (state_q)
      ST_EMPTY: if (xfer_in) state_d = ST_FULL;
      ST_FULL:  if (xfer_out && !xfer_in) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase

    if (xfer_in) begin
      used_d = 1'b0;
      case (sel)
        OPB_REG: begin
          op_d   = reg_val;
          used_d = reg_fwd;
        end
        OPB_IMM_ZX: op_d = {{(XLEN-IMM_W){1'b0}}, bus.immediate};
        OPB_IMM_SX: op_d = {{(XLEN-IMM_W){bus.immediate[IMM_W-1]}}, bus.immediate};
        default:    op_d = last_q;
      endcase
      last_d = op_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      op_q    <= '0;
      used_q  <= 1'b0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      used_q  <= used_d;
      last_q  <= last_d;
    end
  end

  assign bus.out_valid  = (state_q == ST_FULL);
  assign bus.rs2_ALU_in = op_q;
  assign bus.fwd_used   = used_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_ie_operand_mux.sv
// Scoreboard bench for ie_operand_mux: directed plan followed by randomized traffic.
module tb_ie_operand_mux;
  import ie_pkg::*;

  localparam int XLEN    = 32;
  localparam int IMM_W   = 12;
  localparam int NUM_FWD = 2;
`ifdef IE_OPMUX_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  opb_state_e dbg_state;
  int         errors = 0;
  int         checks = 0;
  bit         rand_rdy = 1'b0;

  logic [XLEN:0]   exp_q[$];
  logic [XLEN-1:0] m_last = '0;

  always #5 clk = ~clk;

  ie_operand_mux_if #(.XLEN(XLEN), .IMM_W(IMM_W), .NUM_FWD(NUM_FWD)) bus ();

  ie_operand_mux #(.XLEN(XLEN), .IMM_W(IMM_W), .NUM_FWD(NUM_FWD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: operand by plain arithmetic; returns {fwd_used, operand} and advances last_op.
  function automatic logic [XLEN:0] model(input logic [1:0] s, input logic [XLEN-1:0] r,
                                          input logic [IMM_W-1:0] im, input logic [NUM_FWD-1:0] h,
                                          input logic [NUM_FWD*XLEN-1:0] fd);
    longint unsigned v;
    bit used;
    v = 0;
    used = 1'b0;
    case (s)
      2'd0: begin
        v = r;
        if (FWD_EN) begin
          for (int i = 0; i < NUM_FWD; i++) begin
            if (h[i]) begin
              v = fd[i*XLEN +: XLEN];
              used = 1'b1;
              break;
            end
          end
        end
      end
      2'd1: v = im;
      2'd2: begin
        v = im;
        if (v >= (64'd1 << (IMM_W - 1))) v = v + (64'd1 << XLEN) - (64'd1 << IMM_W);
      end
      default: v = m_last;
    endcase
    m_last = v[XLEN-1:0];
    return {used, v[XLEN-1:0]};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the request has been accepted.
  task automatic drive(input logic [1:0] s, input logic [XLEN-1:0] r, input logic [IMM_W-1:0] im,
                       input logic [NUM_FWD-1:0] h, input logic [NUM_FWD*XLEN-1:0] fd,
                       input bit b2b);
    int n;
    n = 0;
    bus.in_valid  = 1'b1;
    bus.sel       = s;
    bus.rs2_value = r;
    bus.immediate = im;
    bus.fwd_hit   = h;
    bus.fwd_data  = fd;
    @(negedge clk);
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stuck at %0b, required 1 within 40 cycles", bus.in_ready);
    end else begin
      if (b2b) begin
        check("b2b_wait_cycles", 64'(n), 64'd0);
        check("b2b_out_valid", 64'(bus.out_valid), 64'd1);
      end
      exp_q.push_back(model(s, r, im, h, fd));
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every transfer out is compared against the oldest expected operand.
  initial begin
    logic [XLEN:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h with no expected operand queued", bus.rs2_ALU_in);
        end else begin
          e = exp_q.pop_front();
          check("operand", 64'(bus.rs2_ALU_in), 64'(e[XLEN-1:0]));
          check("fwd_used", 64'(bus.fwd_used), 64'(e[XLEN]));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [NUM_FWD*XLEN-1:0] fd;
    int k;
    bus.in_valid  = 1'b0;
    bus.sel       = 2'd0;
    bus.rs2_value = '0;
    bus.immediate = '0;
    bus.fwd_hit   = '0;
    bus.fwd_data  = '0;
    bus.out_ready = 1'b1;

    // Reset
    rst_n = 1'b0;
    idle(3);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_operand", 64'(bus.rs2_ALU_in), 64'd0);
    check("rst_fwd_used", 64'(bus.fwd_used), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_EMPTY));
    rst_n = 1'b1;
    idle(1);

    // Register path, zero and sign extension
    drive(2'd0, 32'h1234_5678, 12'h000, 2'b00, '0, 1'b0);
    drive(2'd1, 32'h0, 12'hFFF, 2'b00, '0, 1'b0);
    drive(2'd2, 32'h0, 12'h800, 2'b00, '0, 1'b0);
    drive(2'd2, 32'h0, 12'h7FF, 2'b00, '0, 1'b0);

    // Forwarding priority
    fd = {32'hBBBB_0000, 32'hAAAA_0000};
    drive(2'd0, 32'h1111_2222, 12'h0, 2'b11, fd, 1'b0);
    drive(2'd0, 32'h1111_2222, 12'h0, 2'b10, fd, 1'b0);
    drive(2'd1, 32'h0, 12'h123, 2'b11, fd, 1'b0);

    // HOLD after sign extension
    drive(2'd2, 32'h0, 12'h800, 2'b00, '0, 1'b0);
    drive(2'd3, 32'h5555_5555, 12'h0, 2'b01, fd, 1'b0);
    idle(1);

    // Stall: register must stay put and refuse new work
    bus.out_ready = 1'b0;
    drive(2'd0, 32'hDEAD_BEEF, 12'h0, 2'b00, '0, 1'b0);
    bus.in_valid  = 1'b1;
    bus.sel       = 2'd0;
    bus.rs2_value = 32'h0BAD_0BAD;
    bus.fwd_hit   = 2'b01;
    bus.fwd_data  = {32'h0, 32'hCAFE_CAFE};
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      check("stall_out_valid", 64'(bus.out_valid), 64'd1);
      check("stall_operand", 64'(bus.rs2_ALU_in), 64'h0000_0000_DEAD_BEEF);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;

    // Reset mid-stall discards the held operand and last_op
    rst_n = 1'b0;
    idle(1);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_operand", 64'(bus.rs2_ALU_in), 64'd0);
    check("midrst_fwd_used", 64'(bus.fwd_used), 64'd0);
    exp_q.delete();
    m_last = '0;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(2'd3, 32'h7777_7777, 12'h0, 2'b00, '0, 1'b0);
    idle(1);

    // Back-to-back with the consumer always ready
    for (int i = 0; i < 8; i++) begin
      drive(2'($urandom_range(0, 3)), $urandom, 12'($urandom), 2'($urandom_range(0, 3)),
            {$urandom, $urandom}, (i != 0));
    end
    idle(2);

    // Random traffic with random consumer back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      drive(2'($urandom_range(0, 3)), $urandom, 12'($urandom), 2'($urandom_range(0, 3)),
            {$urandom, $urandom}, 1'b0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;

    k = 0;
    while (exp_q.size() != 0 && k < 10) begin
      idle(1);
      k++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ie_operand_mux.md
# ie_operand_mux

Parametrised execute-stage operand-B selector that supersedes the fixed 32-bit two-way rs2/immediate mux. It takes the decoded rs2 value, the raw immediate, and forwarded results from later stages. It produces the ALU second operand through a one-deep valid/ready pipeline register, so the execute stage can stall without losing the operand. It sits between the ID/IE boundary and the ALU input.

## Interface

Parameters:
- XLEN, 32, datapath width.
- IMM_W, 12, raw immediate width; must satisfy 1 ≤ IMM_W < XLEN.
- NUM_FWD, 2, number of forwarding sources; must be ≥ 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  upstream operand request valid.
- in_ready  out  1  block can accept a request this cycle.
- sel  in  2  operand source: 0 REG, 1 IMM_ZX, 2 IMM_SX, 3 HOLD.
- rs2_value  in  XLEN  register-file rs2 value.
- immediate  in  IMM_W  raw immediate field.
- fwd_hit  in  NUM_FWD  per-source match flag: the source's destination equals rs2 and is valid.
- fwd_data  in  NUM_FWD*XLEN  forwarded results, packed with source i at [i*XLEN +: XLEN].
- out_valid  out  1  rs2_ALU_in holds a valid operand.
- out_ready  in  1  ALU consumes the operand this cycle.
- rs2_ALU_in  out  XLEN  selected operand B, registered.
- fwd_used  out  1  registered flag: the operand came from a forwarding source.

## Operation

- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is a combinational pass-through, so a full register plus a consumer taking the operand accepts a new request in the same cycle with no bubble.
- Operand on transfer in:
  - REG: rs2_value, unless forwarding overrides (below).
  - IMM_ZX: {(XLEN-IMM_W) zeros, immediate}.
  - IMM_SX: {(XLEN-IMM_W) copies of immediate[IMM_W-1], immediate}.
  - HOLD: the operand of the most recent transfer in, held in the internal register last_op.
- Forwarding applies in REG mode only. The lowest-index set fwd_hit bit wins, since index 0 is the youngest stage. That source's fwd_data slice replaces rs2_value, and fwd_used is set to 1. In every other case fwd_used is 0.
- On every transfer in, rs2_ALU_in, fwd_used and last_op are all updated.
- In HOLD mode:
  - last_op is rewritten with its own value.
  - fwd_used is set to 0.
  - fwd_hit and fwd_data are ignored.
- With no transfer in, rs2_ALU_in and fwd_used hold their values, including while out_valid is low.
- out_valid state machine, two states:
  - EMPTY → FULL on transfer in.
  - FULL → EMPTY on transfer out without transfer in.
  - FULL stays FULL on transfer out with a simultaneous transfer in.
  - FULL stays FULL while out_ready is low.
- When in_valid is low, inputs are don't-care and no register changes.

## Timing

- Latency: one cycle from accepted request to out_valid.
- Throughput: one operand per cycle while out_ready is held high.
- Reset, rst_n low at a rising edge: out_valid=0, rs2_ALU_in=0, fwd_used=0, last_op=0. Reset overrides any simultaneous transfer.
- Reset mid-stall: the operand held in the register is discarded. HOLD issued immediately after reset yields 0.
- in_ready is combinational from out_valid and out_ready. No other output is combinational from any input.
- fwd_hit and fwd_data are sampled only in the accepting cycle. A later change to either does not affect an operand already registered.

## Configuration

- IE_OPMUX_FWD_EN defined: forwarding logic is built exactly as described under Operation.
- IE_OPMUX_FWD_EN undefined:
  - Forwarding logic is not instantiated.
  - fwd_hit and fwd_data remain on the port list but are ignored.
  - REG mode always yields rs2_value.
  - fwd_used is tied to 0.

## Structure

- Shared package ie_pkg holds:
  - enum opb_sel_e (OPB_REG, OPB_IMM_ZX, OPB_IMM_SX, OPB_HOLD) on 2 bits.
  - XLEN_DEF=32 and IMM_W_DEF=12 constants, referenced by the parameter defaults.
- Sub-module ie_fwd_pick, combinational and parametrised by XLEN and NUM_FWD:
  - Inputs: fwd_hit, fwd_data.
  - Outputs: hit_any and the priority-selected data.
  - Instantiated only under IE_OPMUX_FWD_EN.

## Test plan

- Reset and zero-extend: reset, then REG with rs2_value=0x1234_5678 and fwd_hit=0 → next cycle out_valid=1, rs2_ALU_in=0x1234_5678, fwd_used=0. Then IMM_ZX with immediate=0xFFF → 0x0000_0FFF.
- Sign extension: IMM_SX with immediate=0x800 → 0xFFFF_F800. IMM_SX with immediate=0x7FF → 0x0000_07FF.
- Forward priority: REG with fwd_hit=2'b11, fwd_data[0]=0xAAAA_0000, fwd_data[1]=0xBBBB_0000 → 0xAAAA_0000, fwd_used=1. Then fwd_hit=2'b10 → 0xBBBB_0000. Without IE_OPMUX_FWD_EN the same stimulus → rs2_value, fwd_used=0.
- Stall and back-to-back: hold out_ready=0 after one accept → in_ready=0 and the operand is stable for 5 cycles. Then out_ready=1 with in_valid=1 every cycle → one new operand per cycle, no bubble.
- HOLD and reset mid-stall:
  - IMM_SX 0x800, then HOLD → 0xFFFF_F800.
  - Assert rst_n=0 while stalled with out_valid=1 → out_valid=0 next edge.
  - Then HOLD → 0x0000_0000.
